// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM controller: bus widths, zero word,
// FSM state encoding and the word-alignment helper.
package ram_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // The RAM is word organised, so the byte offset is dropped on the bus.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ram_ctrl_wdog.sv
// Bus watchdog for ram_ctrl. Only present when RAM_CTRL_TIMEOUT_EN is
// defined; in the default build this file contributes no module.
`ifdef RAM_CTRL_TIMEOUT_EN
module ram_ctrl_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // The last waiting cycle is the one where the count has already reached TIMEOUT_CYCLES-1.
  assign expired_o = count_en_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Count consecutive unacknowledged bus cycles; any ack, abort or state change restarts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (!count_en_i || expired_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/ram_ctrl.sv
// RAM access controller between the memory stage and a word-wide RAM bus.
// Every access reads the addressed word first (old word returned for
// sub-word merge); stores then write the merged word back.
// Optional bus timeout: define RAM_CTRL_TIMEOUT_EN.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_ready_o,
  output logic                  stall_req_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  output logic                  err_o
);

  state_t                state;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  busy;
  logic                  timeout;
  logic                  unused_addr_lsbs;

  assign busy             = (state == RD) || (state == WR);
  assign unused_addr_lsbs = ^mem_addr_i[1:0];

`ifdef RAM_CTRL_TIMEOUT_EN
  ram_ctrl_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .count_en_i(busy && mem_req_i && !bus_ack_i),
    .expired_o (timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  // Access sequencer: read phase, optional write phase, one-cycle completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rdata_q <= ZERO;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_i) state <= RD;
        end
        RD: begin
          if (!mem_req_i) begin
            state <= IDLE;
          end else if (bus_ack_i) begin
            rdata_q <= bus_rdata_i;
            state   <= mem_we_i ? WR : DONE;
          end else if (timeout) begin
            rdata_q <= ZERO;
            err_q   <= 1'b1;
            state   <= DONE;
          end
        end
        WR: begin
          if (!mem_req_i) begin
            state <= IDLE;
          end else if (bus_ack_i) begin
            state <= DONE;
          end else if (timeout) begin
            rdata_q <= ZERO;
            err_q   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus_req_o   = busy;
  assign bus_we_o    = (state == WR);
  assign bus_addr_o  = busy ? word_addr(mem_addr_i) : '0;
  assign bus_wdata_o = (state == WR) ? mem_wdata_i : ZERO;

  assign mem_rdata_o = rdata_q;
  assign mem_ready_o = (state == DONE);
  assign stall_req_o = mem_req_i && (state != DONE) && !rst_i;
  assign err_o       = err_q;

endmodule
